// File: rtl/dcache_port_arb_pkg.sv
// Shared types and default widths for the data-cache port arbiter.
// The load-burst limiter is only built when DCACHE_ARB_STARVE_GUARD_EN is defined.
package dcache_port_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_BYTE_SEL_WIDTH = 4;
    localparam int unsigned DEF_MAX_LD_BURST   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_BUSY = 2'd1,
        ST_BUSY = 2'd2,
        FENCE   = 2'd3
    } arb_state_e;

    // Width of the consecutive-load counter: wide enough for max_burst, never below 3 bits.
    function automatic int unsigned burst_cnt_width(input int unsigned max_burst);
        int unsigned w;
        w = $clog2(max_burst + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/dcache_port_arb_if.sv
// Bundle of the LSU load port, store-buffer drain port, fence handshake and
// the downstream dcache request/response signals.
// slave  : the arbiter's view.  master : the view of the surrounding requesters/dcache.
interface dcache_port_arb_if
    import dcache_port_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BYTE_SEL_WIDTH = DEF_BYTE_SEL_WIDTH
);

    logic                      ld_req_i;
    logic [ADDR_WIDTH-1:0]     ld_addr_i;
    logic [BYTE_SEL_WIDTH-1:0] ld_sel_byte_i;
    logic                      ld_ack_o;
    logic [DATA_WIDTH-1:0]     ld_rdata_o;
    logic                      ld_hazard_i;

    logic                      stb_req_i;
    logic [ADDR_WIDTH-1:0]     stb_addr_i;
    logic [DATA_WIDTH-1:0]     stb_wdata_i;
    logic [BYTE_SEL_WIDTH-1:0] stb_sel_byte_i;
    logic                      stb_full_i;
    logic                      stb_empty_i;
    logic                      stb_ack_o;

    logic                      fence_i;
    logic                      fence_done_o;

    logic                      arb2dcache_req_o;
    logic [ADDR_WIDTH-1:0]     arb2dcache_addr_o;
    logic [DATA_WIDTH-1:0]     arb2dcache_wdata_o;
    logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte_o;
    logic                      arb2dcache_w_en_o;
    logic                      dcache2arb_ack_i;
    logic [DATA_WIDTH-1:0]     dcache2arb_rdata_i;

    modport slave (
        input  ld_req_i, ld_addr_i, ld_sel_byte_i, ld_hazard_i,
        input  stb_req_i, stb_addr_i, stb_wdata_i, stb_sel_byte_i, stb_full_i, stb_empty_i,
        input  fence_i,
        input  dcache2arb_ack_i, dcache2arb_rdata_i,
        output ld_ack_o, ld_rdata_o, stb_ack_o, fence_done_o,
        output arb2dcache_req_o, arb2dcache_addr_o, arb2dcache_wdata_o,
        output arb2dcache_sel_byte_o, arb2dcache_w_en_o
    );

    modport master (
        output ld_req_i, ld_addr_i, ld_sel_byte_i, ld_hazard_i,
        output stb_req_i, stb_addr_i, stb_wdata_i, stb_sel_byte_i, stb_full_i, stb_empty_i,
        output fence_i,
        output dcache2arb_ack_i, dcache2arb_rdata_i,
        input  ld_ack_o, ld_rdata_o, stb_ack_o, fence_done_o,
        input  arb2dcache_req_o, arb2dcache_addr_o, arb2dcache_wdata_o,
        input  arb2dcache_sel_byte_o, arb2dcache_w_en_o
    );

endinterface

// File: rtl/dcache_arb_req_reg.sv
// Holding register for the request presented to the dcache. Fields are captured
// at grant and stay frozen while req is high; req drops the edge after the ack.
module dcache_arb_req_reg
    import dcache_port_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BYTE_SEL_WIDTH = DEF_BYTE_SEL_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      grant,
    input  logic                      grant_w_en,
    input  logic [ADDR_WIDTH-1:0]     grant_addr,
    input  logic [DATA_WIDTH-1:0]     grant_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] grant_sel_byte,
    input  logic                      dcache_ack,
    output logic                      req,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [BYTE_SEL_WIDTH-1:0] sel_byte,
    output logic                      w_en,
    output logic                      done
);

    logic                      req_r;
    logic [ADDR_WIDTH-1:0]     addr_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic [BYTE_SEL_WIDTH-1:0] sel_byte_r;
    logic                      w_en_r;

    // Capture the winner at grant, release req on ack, otherwise hold everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_r      <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            sel_byte_r <= {BYTE_SEL_WIDTH{1'b0}};
            w_en_r     <= 1'b0;
        end else if (grant) begin
            req_r      <= 1'b1;
            addr_r     <= grant_addr;
            wdata_r    <= grant_wdata;
            sel_byte_r <= grant_sel_byte;
            w_en_r     <= grant_w_en;
        end else if (req_r && dcache_ack) begin
            req_r      <= 1'b0;
        end else begin
            req_r      <= req_r;
        end
    end

    // An ack only completes a transaction while one is outstanding.
    assign done     = req_r & dcache_ack;
    assign req      = req_r;
    assign addr     = addr_r;
    assign wdata    = wdata_r;
    assign sel_byte = sel_byte_r;
    assign w_en     = w_en_r;

endmodule

// File: rtl/dcache_port_arb.sv
// Arbiter between the LSU load port and the store-buffer drain port for a
// single dcache port, with fence (drain-all) support.
// Optional build macro: DCACHE_ARB_STARVE_GUARD_EN (bounds consecutive loads
// granted while a store is waiting to MAX_LD_BURST).
module dcache_port_arb
    import dcache_port_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BYTE_SEL_WIDTH = DEF_BYTE_SEL_WIDTH,
    parameter int unsigned MAX_LD_BURST   = DEF_MAX_LD_BURST
) (
    input  logic             clk,
    input  logic             rst_n,
    dcache_port_arb_if.slave bus
);

    arb_state_e                state_r;
    arb_state_e                state_s;
    logic                      grant_ld_s;
    logic                      grant_st_s;
    logic                      fence_done_s;
    logic                      fence_pend_set_s;
    logic                      fence_pend_clr_s;
    logic                      fence_pend_r;
    logic                      starve_s;

    logic [ADDR_WIDTH-1:0]     grant_addr_s;
    logic [DATA_WIDTH-1:0]     grant_wdata_s;
    logic [BYTE_SEL_WIDTH-1:0] grant_sel_s;

    logic                      req_busy_s;
    logic                      txn_done_s;
    logic                      req_w_en_s;
    logic [ADDR_WIDTH-1:0]     req_addr_s;
    logic [DATA_WIDTH-1:0]     req_wdata_s;
    logic [BYTE_SEL_WIDTH-1:0] req_sel_s;

    logic                      ld_ack_r;
    logic                      stb_ack_r;
    logic                      fence_done_r;
    logic [DATA_WIDTH-1:0]     ld_rdata_r;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
    localparam int unsigned          BURST_W   = burst_cnt_width(MAX_LD_BURST);
    localparam logic [BURST_W-1:0]   BURST_MAX = BURST_W'(MAX_LD_BURST);
    logic [BURST_W-1:0]              ld_burst_r;

    // Count loads granted while a store waits; any store grant or an idle store port resets it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_burst_r <= {BURST_W{1'b0}};
        end else if (!bus.stb_req_i || grant_st_s) begin
            ld_burst_r <= {BURST_W{1'b0}};
        end else if (grant_ld_s && (ld_burst_r < BURST_MAX)) begin
            ld_burst_r <= ld_burst_r + BURST_W'(1);
        end else begin
            ld_burst_r <= ld_burst_r;
        end
    end

    assign starve_s = bus.stb_req_i && (ld_burst_r >= BURST_MAX);
`else
    assign starve_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, grant decision and fence bookkeeping.
    always_comb begin
        state_s          = state_r;
        grant_ld_s       = 1'b0;
        grant_st_s       = 1'b0;
        fence_done_s     = 1'b0;
        fence_pend_set_s = 1'b0;
        fence_pend_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.fence_i || fence_pend_r) begin
                    fence_pend_clr_s = 1'b1;
                    if (bus.stb_empty_i) begin
                        fence_done_s = 1'b1;
                        state_s      = IDLE;
                    end else begin
                        state_s      = FENCE;
                    end
                end else if (bus.stb_req_i && (bus.ld_hazard_i || bus.stb_full_i || starve_s)) begin
                    grant_st_s = 1'b1;
                    state_s    = ST_BUSY;
                end else if (bus.ld_req_i && !bus.ld_hazard_i) begin
                    grant_ld_s = 1'b1;
                    state_s    = LD_BUSY;
                end else if (bus.stb_req_i) begin
                    grant_st_s = 1'b1;
                    state_s    = ST_BUSY;
                end else begin
                    state_s    = IDLE;
                end
            end
            LD_BUSY, ST_BUSY: begin
                // A fence seen mid-transaction is remembered and served after the ack.
                if (bus.fence_i) begin
                    fence_pend_set_s = 1'b1;
                end else begin
                    fence_pend_set_s = 1'b0;
                end
                if (txn_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            FENCE: begin
                // Loads are blocked; drain stores one at a time until the buffer is empty.
                if (req_busy_s) begin
                    state_s = FENCE;
                end else if (bus.stb_empty_i) begin
                    fence_done_s = 1'b1;
                    state_s      = IDLE;
                end else if (bus.stb_req_i) begin
                    grant_st_s = 1'b1;
                    state_s    = FENCE;
                end else begin
                    state_s    = FENCE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Pending-fence flag for fences that arrive while a transaction is outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fence_pend_r <= 1'b0;
        end else if (fence_pend_clr_s) begin
            fence_pend_r <= 1'b0;
        end else if (fence_pend_set_s) begin
            fence_pend_r <= 1'b1;
        end else begin
            fence_pend_r <= fence_pend_r;
        end
    end

    // Select the payload of the winning requester.
    always_comb begin
        grant_addr_s  = bus.ld_addr_i;
        grant_wdata_s = {DATA_WIDTH{1'b0}};
        grant_sel_s   = bus.ld_sel_byte_i;
        if (grant_st_s) begin
            grant_addr_s  = bus.stb_addr_i;
            grant_wdata_s = bus.stb_wdata_i;
            grant_sel_s   = bus.stb_sel_byte_i;
        end else begin
            grant_addr_s  = bus.ld_addr_i;
            grant_wdata_s = {DATA_WIDTH{1'b0}};
            grant_sel_s   = bus.ld_sel_byte_i;
        end
    end

    dcache_arb_req_reg #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH)
    ) u_req_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .grant          (grant_ld_s | grant_st_s),
        .grant_w_en     (grant_st_s),
        .grant_addr     (grant_addr_s),
        .grant_wdata    (grant_wdata_s),
        .grant_sel_byte (grant_sel_s),
        .dcache_ack     (bus.dcache2arb_ack_i),
        .req            (req_busy_s),
        .addr           (req_addr_s),
        .wdata          (req_wdata_s),
        .sel_byte       (req_sel_s),
        .w_en           (req_w_en_s),
        .done           (txn_done_s)
    );

    // Completion pulses and load data capture, one cycle after the dcache ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_ack_r     <= 1'b0;
            stb_ack_r    <= 1'b0;
            fence_done_r <= 1'b0;
            ld_rdata_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            ld_ack_r     <= txn_done_s & ~req_w_en_s;
            stb_ack_r    <= txn_done_s & req_w_en_s;
            fence_done_r <= fence_done_s;
            if (txn_done_s && !req_w_en_s) begin
                ld_rdata_r <= bus.dcache2arb_rdata_i;
            end else begin
                ld_rdata_r <= ld_rdata_r;
            end
        end
    end

    assign bus.ld_ack_o              = ld_ack_r;
    assign bus.ld_rdata_o            = ld_rdata_r;
    assign bus.stb_ack_o             = stb_ack_r;
    assign bus.fence_done_o          = fence_done_r;
    assign bus.arb2dcache_req_o      = req_busy_s;
    assign bus.arb2dcache_addr_o     = req_addr_s;
    assign bus.arb2dcache_wdata_o    = req_wdata_s;
    assign bus.arb2dcache_sel_byte_o = req_sel_s;
    assign bus.arb2dcache_w_en_o     = req_w_en_s;

endmodule

// File: tb/tb_dcache_port_arb.sv
// Scoreboard bench for dcache_port_arb: each test pushes the expected dcache
// issues and completions, a negedge monitor pops and compares them, and a small
// dcache model acks every request in its second cycle.
module tb_dcache_port_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam byte K_LD = 8'h4C;
    localparam byte K_ST = 8'h53;
    localparam byte K_FN = 8'h46;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    localparam int S_IDX = 4;
`else
    localparam int S_IDX = 5;
`endif

    typedef struct {
        byte         kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        w_en;
        logic [3:0]  sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_port_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW)) bus ();

    dcache_port_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW), .MAX_LD_BURST(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        iss_q[$];
    exp_t        cmp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          last_len = 0;
    int          req_len = 0;
    bit          req_prev = 1'b0;
    logic        dc_en = 1'b1;
    logic        force_ack = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_sel;
    logic        h_wen;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    task automatic push_iss(input byte k, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [3:0] s);
        exp_t e;
        e.kind = k; e.addr = a; e.data = d; e.w_en = w; e.sel = s;
        iss_q.push_back(e);
    endtask

    task automatic push_cmp(input byte k, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.addr = 32'h0; e.data = d; e.w_en = 1'b0; e.sel = 4'h0;
        cmp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag, input byte k, input logic [31:0] d);
        exp_t e;
        if (cmp_q.size() == 0) begin
            check_eq({tag, "_unexpected"}, 64'(k), 64'h0);
        end else begin
            e = cmp_q.pop_front();
            check_eq({tag, "_kind"}, 64'(k), 64'(e.kind));
            if (k == K_LD && e.kind == K_LD) check_eq({tag, "_rdata"}, 64'(d), 64'(e.data));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"},     64'(bus.arb2dcache_req_o),      64'h0);
        check_eq({tag, "_addr"},    64'(bus.arb2dcache_addr_o),     64'h0);
        check_eq({tag, "_wdata"},   64'(bus.arb2dcache_wdata_o),    64'h0);
        check_eq({tag, "_sel"},     64'(bus.arb2dcache_sel_byte_o), 64'h0);
        check_eq({tag, "_wen"},     64'(bus.arb2dcache_w_en_o),     64'h0);
        check_eq({tag, "_ld_ack"},  64'(bus.ld_ack_o),              64'h0);
        check_eq({tag, "_stb_ack"}, 64'(bus.stb_ack_o),             64'h0);
        check_eq({tag, "_fdone"},   64'(bus.fence_done_o),          64'h0);
        check_eq({tag, "_rdata"},   64'(bus.ld_rdata_o),            64'h0);
    endtask

    function automatic logic out_sel(input int s);
        case (s)
            0:       return bus.ld_ack_o;
            1:       return bus.stb_ack_o;
            2:       return bus.fence_done_o;
            3:       return bus.arb2dcache_req_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_out(input int s, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_sel(s)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq({tag, "_timeout"}, 64'h0, 64'h1);
    endtask

    // Monitor + dcache model.
    initial begin
        exp_t it;
        bus.dcache2arb_ack_i   = 1'b0;
        bus.dcache2arb_rdata_i = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (bus.ld_ack_o)     pop_cmp("ld_ack", K_LD, bus.ld_rdata_o);
            if (bus.stb_ack_o)    pop_cmp("stb_ack", K_ST, 32'h0);
            if (bus.fence_done_o) pop_cmp("fence_done", K_FN, 32'h0);
            if (bus.arb2dcache_req_o && !req_prev) begin
                req_len = 1;
                h_addr  = bus.arb2dcache_addr_o;
                h_wdata = bus.arb2dcache_wdata_o;
                h_sel   = bus.arb2dcache_sel_byte_o;
                h_wen   = bus.arb2dcache_w_en_o;
                if (iss_q.size() == 0) begin
                    check_eq("issue_unexpected", 64'h1, 64'h0);
                end else begin
                    it = iss_q.pop_front();
                    check_eq("iss_wen",  64'(h_wen),  64'(it.w_en));
                    check_eq("iss_addr", 64'(h_addr), 64'(it.addr));
                    check_eq("iss_sel",  64'(h_sel),  64'(it.sel));
                    if (it.w_en) check_eq("iss_wdata", 64'(h_wdata), 64'(it.data));
                end
            end else if (bus.arb2dcache_req_o) begin
                req_len++;
                check_eq("iss_hold_data", {bus.arb2dcache_addr_o, bus.arb2dcache_wdata_o}, {h_addr, h_wdata});
                check_eq("iss_hold_ctl", 64'({bus.arb2dcache_sel_byte_o, bus.arb2dcache_w_en_o}), 64'({h_sel, h_wen}));
            end else if (req_prev) begin
                last_len = req_len;
            end
            req_prev = bus.arb2dcache_req_o;
            if (force_ack) begin
                bus.dcache2arb_ack_i   = 1'b1;
                bus.dcache2arb_rdata_i = 32'hBAD0_BAD0;
            end else if (bus.arb2dcache_req_o && dc_en && req_len == 2) begin
                bus.dcache2arb_ack_i   = 1'b1;
                bus.dcache2arb_rdata_i = bus.arb2dcache_w_en_o ? 32'hBAD0_BAD0 : rd_data(bus.arb2dcache_addr_o);
            end else begin
                bus.dcache2arb_ack_i   = 1'b0;
                bus.dcache2arb_rdata_i = 32'hBAD0_BAD0;
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        int nl, ns, nf;
        rst_n = 1'b0;
        bus.ld_req_i = 1'b0; bus.ld_addr_i = 32'h0; bus.ld_sel_byte_i = 4'h0; bus.ld_hazard_i = 1'b0;
        bus.stb_req_i = 1'b0; bus.stb_addr_i = 32'h0; bus.stb_wdata_i = 32'h0; bus.stb_sel_byte_i = 4'h0;
        bus.stb_full_i = 1'b0; bus.stb_empty_i = 1'b1; bus.fence_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Plain load.
        push_iss(K_LD, 32'h100, 32'h0, 1'b0, 4'hF);
        push_cmp(K_LD, 32'hDEAD_BEEF);
        bus.ld_addr_i = 32'h100; bus.ld_sel_byte_i = 4'hF; bus.ld_req_i = 1'b1;
        wait_out(0, "t1_ld_ack");
        bus.ld_req_i = 1'b0;
        @(negedge clk);
        check_eq("t1_req_len", 64'(last_len), 64'd2);
        check_eq("t1_ld_ack_pulse", 64'(bus.ld_ack_o), 64'h0);
        check_eq("t1_rdata_hold", 64'(bus.ld_rdata_o), 64'hDEAD_BEEF);

        // Hazard: store drains first.
        push_iss(K_ST, 32'h100, 32'h1122_3344, 1'b1, 4'hF);
        push_iss(K_LD, 32'h200, 32'h0, 1'b0, 4'hF);
        push_cmp(K_ST, 32'h0);
        push_cmp(K_LD, rd_data(32'h200));
        bus.ld_addr_i = 32'h200; bus.ld_hazard_i = 1'b1; bus.ld_req_i = 1'b1;
        bus.stb_addr_i = 32'h100; bus.stb_wdata_i = 32'h1122_3344; bus.stb_sel_byte_i = 4'hF;
        bus.stb_req_i = 1'b1; bus.stb_empty_i = 1'b0;
        wait_out(1, "t2_stb_ack");
        bus.stb_req_i = 1'b0; bus.ld_hazard_i = 1'b0; bus.stb_empty_i = 1'b1;
        wait_out(0, "t2_ld_ack");
        bus.ld_req_i = 1'b0;
        @(negedge clk);

        // Simultaneous with store buffer full.
        push_iss(K_ST, 32'h400, 32'hCAFE_F00D, 1'b1, 4'h3);
        push_iss(K_LD, 32'h300, 32'h0, 1'b0, 4'hF);
        push_cmp(K_ST, 32'h0);
        push_cmp(K_LD, rd_data(32'h300));
        bus.ld_addr_i = 32'h300; bus.ld_req_i = 1'b1;
        bus.stb_addr_i = 32'h400; bus.stb_wdata_i = 32'hCAFE_F00D; bus.stb_sel_byte_i = 4'h3;
        bus.stb_full_i = 1'b1; bus.stb_empty_i = 1'b0; bus.stb_req_i = 1'b1;
        wait_out(1, "t3_stb_ack");
        bus.stb_req_i = 1'b0; bus.stb_full_i = 1'b0; bus.stb_empty_i = 1'b1;
        wait_out(0, "t3_ld_ack");
        bus.ld_req_i = 1'b0;
        @(negedge clk);

        // Continuous load + store pressure.
        for (int k = 0; k < 6; k++) begin
            if (k == S_IDX) begin
                push_iss(K_ST, 32'h600, 32'h0BAD_F00D, 1'b1, 4'hC);
                push_cmp(K_ST, 32'h0);
            end else begin
                push_iss(K_LD, 32'h500, 32'h0, 1'b0, 4'hF);
                push_cmp(K_LD, rd_data(32'h500));
            end
        end
        bus.ld_addr_i = 32'h500; bus.ld_sel_byte_i = 4'hF; bus.ld_req_i = 1'b1;
        bus.stb_addr_i = 32'h600; bus.stb_wdata_i = 32'h0BAD_F00D; bus.stb_sel_byte_i = 4'hC;
        bus.stb_empty_i = 1'b0; bus.stb_req_i = 1'b1;
        nl = 0; ns = 0;
        for (int i = 0; i < 200 && !(nl == 5 && ns == 1); i++) begin
            @(negedge clk);
            if (bus.ld_ack_o) begin
                nl++;
                if (nl == 5) bus.ld_req_i = 1'b0;
            end
            if (bus.stb_ack_o) begin
                ns++;
                bus.stb_req_i = 1'b0; bus.stb_empty_i = 1'b1;
            end
        end
        check_eq("t4_ld_count", 64'(nl), 64'd5);
        check_eq("t4_st_count", 64'(ns), 64'd1);
        @(negedge clk);

        // Fence during a load with three stores pending.
        push_iss(K_LD, 32'h700, 32'h0, 1'b0, 4'hF);
        push_iss(K_ST, 32'h800, 32'h1000_0000, 1'b1, 4'hF);
        push_iss(K_ST, 32'h804, 32'h1000_0001, 1'b1, 4'hF);
        push_iss(K_ST, 32'h808, 32'h1000_0002, 1'b1, 4'hF);
        push_iss(K_LD, 32'h900, 32'h0, 1'b0, 4'hF);
        push_cmp(K_LD, rd_data(32'h700));
        push_cmp(K_ST, 32'h0); push_cmp(K_ST, 32'h0); push_cmp(K_ST, 32'h0);
        push_cmp(K_FN, 32'h0);
        push_cmp(K_LD, rd_data(32'h900));
        bus.ld_addr_i = 32'h700; bus.ld_req_i = 1'b1;
        bus.stb_addr_i = 32'h800; bus.stb_wdata_i = 32'h1000_0000; bus.stb_sel_byte_i = 4'hF;
        bus.stb_empty_i = 1'b0; bus.stb_req_i = 1'b1;
        wait_out(3, "t5_busy");
        bus.fence_i = 1'b1;
        @(negedge clk);
        bus.fence_i = 1'b0;
        nl = 0; ns = 0; nf = 0;
        for (int i = 0; i < 300 && !(nl == 2 && nf == 1); i++) begin
            @(negedge clk);
            if (bus.ld_ack_o) begin
                nl++;
                if (nl == 1) bus.ld_addr_i = 32'h900;
                else bus.ld_req_i = 1'b0;
            end
            if (bus.stb_ack_o) begin
                ns++;
                if (ns == 1) check_eq("t5_rdata_hold", 64'(bus.ld_rdata_o), 64'(rd_data(32'h700)));
                if (ns == 3) begin
                    bus.stb_req_i = 1'b0; bus.stb_empty_i = 1'b1;
                end else begin
                    bus.stb_addr_i = bus.stb_addr_i + 32'd4;
                    bus.stb_wdata_i = bus.stb_wdata_i + 32'd1;
                end
            end
            if (bus.fence_done_o) nf++;
        end
        check_eq("t5_ld_count", 64'(nl), 64'd2);
        check_eq("t5_st_count", 64'(ns), 64'd3);
        check_eq("t5_fence_count", 64'(nf), 64'd1);
        @(negedge clk);

        // Fence with an already empty store buffer.
        push_cmp(K_FN, 32'h0);
        bus.fence_i = 1'b1;
        @(negedge clk);
        check_eq("t6_done", 64'(bus.fence_done_o), 64'h1);
        bus.fence_i = 1'b0;
        @(negedge clk);
        check_eq("t6_done_pulse", 64'(bus.fence_done_o), 64'h0);

        // Reset during a store, then a stray ack.
        dc_en = 1'b0;
        push_iss(K_ST, 32'hA00, 32'h55AA_55AA, 1'b1, 4'hF);
        bus.stb_addr_i = 32'hA00; bus.stb_wdata_i = 32'h55AA_55AA; bus.stb_sel_byte_i = 4'hF;
        bus.stb_empty_i = 1'b0; bus.stb_req_i = 1'b1;
        wait_out(3, "t7_busy");
        @(negedge clk);
        rst_n = 1'b0; bus.stb_req_i = 1'b0; bus.stb_empty_i = 1'b1;
        @(negedge clk);
        check_all_zero("t7_in_reset");
        rst_n = 1'b1; dc_en = 1'b1; force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t7_no_stb_ack", 64'(bus.stb_ack_o), 64'h0);
            check_eq("t7_no_req", 64'(bus.arb2dcache_req_o), 64'h0);
        end
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("t7_post");
        push_iss(K_LD, 32'hB00, 32'h0, 1'b0, 4'h1);
        push_cmp(K_LD, rd_data(32'hB00));
        bus.ld_addr_i = 32'hB00; bus.ld_sel_byte_i = 4'h1; bus.ld_req_i = 1'b1;
        wait_out(0, "t7_ld_ack");
        bus.ld_req_i = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("iss_q_empty", 64'(iss_q.size()), 64'h0);
        check_eq("cmp_q_empty", 64'(cmp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_port_arb.md
DCACHE_PORT_ARB -- requirements
Module: dcache_port_arb

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; BYTE_SEL_WIDTH, 4, byte-select width; MAX_LD_BURST, 4, consecutive load grants allowed while a store waits.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- ld_req_i, in, 1, LSU load request.
- ld_addr_i, in, ADDR_WIDTH, load address.
- ld_sel_byte_i, in, BYTE_SEL_WIDTH, load byte select.
- ld_ack_o, out, 1, load complete pulse.
- ld_rdata_o, out, DATA_WIDTH, load data.
- ld_hazard_i, in, 1, load address matches a pending store-buffer entry.
- stb_req_i, in, 1, store-buffer drain request.
- stb_addr_i, in, ADDR_WIDTH, store address.
- stb_wdata_i, in, DATA_WIDTH, store data.
- stb_sel_byte_i, in, BYTE_SEL_WIDTH, store byte select.
- stb_full_i, in, 1, store buffer full.
- stb_empty_i, in, 1, store buffer empty.
- stb_ack_o, out, 1, store complete pulse.
- fence_i, in, 1, drain-all request.
- fence_done_o, out, 1, fence complete pulse.
- arb2dcache_req_o, out, 1, dcache request.
- arb2dcache_addr_o, out, ADDR_WIDTH, dcache address.
- arb2dcache_wdata_o, out, DATA_WIDTH, dcache write data.
- arb2dcache_sel_byte_o, out, BYTE_SEL_WIDTH, dcache byte select.
- arb2dcache_w_en_o, out, 1, 1 = write, 0 = read.
- dcache2arb_ack_i, in, 1, dcache completion.
- dcache2arb_rdata_i, in, DATA_WIDTH, dcache read data.

Function
REQ-003 The FSM SHALL have four states: IDLE, LD_BUSY, ST_BUSY, FENCE.
REQ-004 Grant priority in IDLE SHALL be, highest first: (a) fence_i, which enters FENCE; (b) stb_req_i with ld_hazard_i or stb_full_i, which grants the store; (c) ld_req_i without ld_hazard_i, which grants the load; (d) stb_req_i, which grants the store.
REQ-005 On grant at cycle N, the arbiter SHALL register the address, byte select, wdata and w_en of the winning request.
REQ-006 arb2dcache_req_o SHALL go high at N+1 and hold, with all fields stable, until the cycle dcache2arb_ack_i is sampled high.
REQ-007 When dcache2arb_ack_i is sampled at cycle M, the arbiter SHALL drop arb2dcache_req_o at M+1 and pulse ld_ack_o or stb_ack_o for exactly one cycle at M+1.
REQ-008 On a load, ld_rdata_o SHALL be dcache2arb_rdata_i registered at M and held until the next load ack.
REQ-009 The FSM SHALL return to IDLE at M+1, and a new grant MAY occur in that cycle, giving back-to-back transactions one idle cycle apart.
REQ-010 A load with ld_hazard_i high SHALL never be granted; it waits until a store drain clears the hazard.
REQ-011 In FENCE, loads SHALL be blocked and stores granted whenever stb_req_i is high. When stb_empty_i is high and no transaction is outstanding, fence_done_o SHALL pulse once and the FSM SHALL return to IDLE.
REQ-012 fence_i arriving during LD_BUSY or ST_BUSY SHALL be acted on only after the outstanding transaction acks.
REQ-013 fence_i with stb_empty_i already high in IDLE SHALL pulse fence_done_o at the next cycle.
REQ-014 dcache2arb_ack_i while in IDLE SHALL be ignored.
REQ-015 Requesters SHALL hold req and payload until acked; the arbiter samples the payload only at grant.

Reset
REQ-016 When rst_n is low at a clock edge, the FSM SHALL go to IDLE and every output SHALL be 0 (all req, ack, done, addr, wdata, sel_byte, w_en, rdata), with the burst counter cleared.
REQ-017 Reset mid-transaction SHALL abandon the transaction, and an ack arriving after reset SHALL be ignored per REQ-014.

Configuration
REQ-018 With macro DCACHE_ARB_STARVE_GUARD_EN defined, a 3-bit-minimum counter SHALL count consecutive load grants made while stb_req_i is high.
REQ-019 Under DCACHE_ARB_STARVE_GUARD_EN, when the counter reaches MAX_LD_BURST the next IDLE grant SHALL go to the store; any store grant, or stb_req_i low, clears the counter.
REQ-020 Without DCACHE_ARB_STARVE_GUARD_EN, no counter SHALL exist and priority SHALL be strictly per REQ-004.

Structure
REQ-021 A shared package SHALL hold the state enum type (IDLE, LD_BUSY, ST_BUSY, FENCE) and the default width constants.
REQ-022 One sub-module, dcache_arb_req_reg, SHALL hold the registered dcache request fields and their hold-until-ack logic; the FSM and priority logic stay in the top module.

Verification
REQ-023 Load only: ld_req=1, addr 0x100, dcache ack 2 cycles after req with rdata 0xDEADBEEF. Required: req_o high for 2 cycles, w_en_o=0, ld_ack_o pulses once, ld_rdata_o=0xDEADBEEF.
REQ-024 Hazard: ld_req=1 with ld_hazard=1, stb_req=1 at addr 0x100 wdata 0x11223344. Required: store issued first with w_en_o=1; load issued only after hazard drops.
REQ-025 Starvation (macro defined, MAX_LD_BURST=4): ld_req and stb_req held high continuously. Required: grant sequence L,L,L,L,S,L...; without the macro, S is never granted until ld_req drops.
REQ-026 Fence: 3 stores pending, fence_i pulsed during a load. Required: the load completes, then 3 store acks, then fence_done_o pulses once after stb_empty_i rises; no load is granted in between.
REQ-027 Reset: rst_n low during ST_BUSY, then dcache ack arrives after release. Required: all outputs 0, stb_ack_o never pulses, FSM in IDLE.
REQ-028 Simultaneous: ld_req=1, stb_req=1, stb_full=1 in IDLE. Required: store granted first.
